// File: rtl/tx_resp_arbiter_if.sv
// Source and FIFO-write signals shared by tx_resp_arbiter and its environment.
// Handshake: each *_VALID/ERR_VLD is a one-cycle pulse qualifying its data; a byte is written when TX_D_VLD is high, which never happens while FIFO_FULL is high.
interface tx_resp_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_WIDTH  = 16
);
    logic [OUT_WIDTH-1:0]  ALU_OUT;
    logic                  ALU_OUT_VALID;
    logic [DATA_WIDTH-1:0] RF_RdData;
    logic                  RdData_VALID;
    logic [DATA_WIDTH-1:0] ERR_CODE;
    logic                  ERR_VLD;
    logic                  FIFO_FULL;
    logic [DATA_WIDTH-1:0] TX_P_Data;
    logic                  TX_D_VLD;

    modport master (
        input  ALU_OUT, ALU_OUT_VALID, RF_RdData, RdData_VALID,
        input  ERR_CODE, ERR_VLD, FIFO_FULL,
        output TX_P_Data, TX_D_VLD
    );

    modport slave (
        output ALU_OUT, ALU_OUT_VALID, RF_RdData, RdData_VALID,
        output ERR_CODE, ERR_VLD, FIFO_FULL,
        input  TX_P_Data, TX_D_VLD
    );
endinterface

// File: rtl/tx_resp_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among ALU (two-byte), RF and error responses.
// Each source owns a one-entry holding buffer; the ALU byte pair is always written back to back.
module tx_resp_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_WIDTH  = 16
) (
    input  logic                CLK,
    input  logic                RST,
    tx_resp_arbiter_if.master   bus,
    output logic                BUSY,
    output logic [2:0]          PEND,
    output logic [2:0]          OVF,
    output logic [1:0]          state_dbg
);

    typedef enum logic [1:0] {IDLE = 2'd0, SEND_B0 = 2'd1, SEND_B1 = 2'd2} state_t;

    localparam logic [1:0] SRC_ALU = 2'd0;
    localparam logic [1:0] SRC_RF  = 2'd1;
    localparam logic [1:0] SRC_ERR = 2'd2;

    state_t                state, state_nxt;
    logic [1:0]            grant, grant_nxt;
    logic [1:0]            last_ptr, last_ptr_nxt;
    logic [1:0]            pick_src;
    logic [DATA_WIDTH-1:0] tx_data, tx_data_nxt;
    logic [OUT_WIDTH-1:0]  alu_hold;
    logic [DATA_WIDTH-1:0] rf_hold, err_hold;
    logic [2:0]            pend, ovf;
    logic [2:0]            done;
    logic                  wr;

    // First pending source strictly after the last grant, in ALU -> RF -> ERR order.
    function automatic logic [1:0] pick(input logic [2:0] p, input logic [1:0] ptr);
        logic [1:0] r;
        r = SRC_ALU;
        case (ptr)
            SRC_ERR: r = p[0] ? SRC_ALU : (p[1] ? SRC_RF  : SRC_ERR);
            SRC_ALU: r = p[1] ? SRC_RF  : (p[2] ? SRC_ERR : SRC_ALU);
            default: r = p[2] ? SRC_ERR : (p[0] ? SRC_ALU : SRC_RF);
        endcase
        return r;
    endfunction

    assign pick_src = pick(pend, last_ptr);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            grant    <= SRC_ALU;
            last_ptr <= SRC_ERR;
            tx_data  <= '0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            last_ptr <= last_ptr_nxt;
            tx_data  <= tx_data_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        last_ptr_nxt = last_ptr;
        tx_data_nxt  = tx_data;
        wr           = 1'b0;
        done         = 3'b000;
        case (state)
            IDLE: begin
                if (|pend) begin
                    grant_nxt    = pick_src;
                    last_ptr_nxt = pick_src;
                    state_nxt    = SEND_B0;
                    case (pick_src)
                        SRC_ALU: tx_data_nxt = alu_hold[DATA_WIDTH-1:0];
                        SRC_RF:  tx_data_nxt = rf_hold;
                        default: tx_data_nxt = err_hold;
                    endcase
                end
            end
            SEND_B0: begin
                wr = ~bus.FIFO_FULL;
                if (wr) begin
                    if (grant == SRC_ALU) begin
                        tx_data_nxt = alu_hold[OUT_WIDTH-1:DATA_WIDTH];
                        state_nxt   = SEND_B1;
                    end else begin
                        done[grant] = 1'b1;
                        state_nxt   = IDLE;
                    end
                end
            end
            SEND_B1: begin
                wr = ~bus.FIFO_FULL;
                if (wr) begin
                    done[SRC_ALU] = 1'b1;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A pulse arriving in its own completion cycle refills the buffer instead of being dropped.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pend     <= 3'b000;
            ovf      <= 3'b000;
            alu_hold <= '0;
            rf_hold  <= '0;
            err_hold <= '0;
        end else begin
            if (bus.ALU_OUT_VALID) begin
                if (!pend[0] || done[0]) begin
                    alu_hold <= bus.ALU_OUT;
                    pend[0]  <= 1'b1;
                end else begin
                    ovf[0]   <= 1'b1;
                end
            end else if (done[0]) begin
                pend[0] <= 1'b0;
            end

            if (bus.RdData_VALID) begin
                if (!pend[1] || done[1]) begin
                    rf_hold <= bus.RF_RdData;
                    pend[1] <= 1'b1;
                end else begin
                    ovf[1]  <= 1'b1;
                end
            end else if (done[1]) begin
                pend[1] <= 1'b0;
            end

            if (bus.ERR_VLD) begin
                if (!pend[2] || done[2]) begin
                    err_hold <= bus.ERR_CODE;
                    pend[2]  <= 1'b1;
                end else begin
                    ovf[2]   <= 1'b1;
                end
            end else if (done[2]) begin
                pend[2] <= 1'b0;
            end
        end
    end

    assign bus.TX_D_VLD  = wr;
    assign bus.TX_P_Data = tx_data;
    assign BUSY          = (state != IDLE);
    assign PEND          = pend;
    assign OVF           = ovf;
    assign state_dbg     = state;

endmodule

// File: tb/tb_tx_resp_arbiter.sv
// Directed bench for tx_resp_arbiter: a write monitor pops an expected-byte queue filled as pulses are driven.
module tb_tx_resp_arbiter;
  logic       clk;
  logic       rst_n;
  logic       busy;
  logic [2:0] pend;
  logic [2:0] ovf;
  logic [1:0] state_dbg;

  logic [7:0] exp_q[$];
  int n_checks;
  int n_fail;
  int wr_cnt;
  int wr_mark;

  tx_resp_arbiter_if #(.DATA_WIDTH(8), .OUT_WIDTH(16)) bus ();

  tx_resp_arbiter #(.DATA_WIDTH(8), .OUT_WIDTH(16)) dut (
    .CLK       (clk),
    .RST       (rst_n),
    .bus       (bus),
    .BUSY      (busy),
    .PEND      (pend),
    .OVF       (ovf),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.ALU_OUT       = '0;
    bus.ALU_OUT_VALID = 1'b0;
    bus.RF_RdData     = '0;
    bus.RdData_VALID  = 1'b0;
    bus.ERR_CODE      = '0;
    bus.ERR_VLD       = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    bus.FIFO_FULL = 1'b0;
    exp_q.delete();
    next_cyc();
    next_cyc();
    rst_n = 1'b1;
    next_cyc();
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      next_cyc();
    end
    next_cyc();
    check("drain_empty", 16'(exp_q.size()), 16'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.TX_D_VLD) begin
      wr_cnt++;
      if (exp_q.size() == 0) check("spurious_wr", {15'd0, bus.TX_D_VLD}, 16'd0);
      else check("wr_data", {8'd0, bus.TX_P_Data}, {8'd0, exp_q.pop_front()});
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    wr_cnt   = 0;
    rst_n    = 1'b0;
    clear_inputs();
    bus.FIFO_FULL = 1'b0;
    #12;
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_pend", {13'd0, pend}, 16'd0);
    check("rst_ovf", {13'd0, ovf}, 16'd0);
    check("rst_vld", {15'd0, bus.TX_D_VLD}, 16'd0);
    check("rst_data", {8'd0, bus.TX_P_Data}, 16'd0);
    check("rst_state", {14'd0, state_dbg}, 16'd0);
    do_reset();

    // Single RF byte: write two cycles after the pulse.
    bus.RdData_VALID = 1'b1; bus.RF_RdData = 8'h5A; exp_q.push_back(8'h5A);
    next_cyc(); clear_inputs();
    at_neg();
    check("rf_n1_pend", {13'd0, pend}, 16'h2);
    check("rf_n1_vld", {15'd0, bus.TX_D_VLD}, 16'd0);
    check("rf_n1_busy", {15'd0, busy}, 16'd0);
    next_cyc(); at_neg();
    check("rf_n2_vld", {15'd0, bus.TX_D_VLD}, 16'd1);
    check("rf_n2_busy", {15'd0, busy}, 16'd1);
    check("rf_n2_data", {8'd0, bus.TX_P_Data}, 16'h5A);
    next_cyc(); at_neg();
    check("rf_n3_vld", {15'd0, bus.TX_D_VLD}, 16'd0);
    check("rf_n3_busy", {15'd0, busy}, 16'd0);
    check("rf_n3_pend", {13'd0, pend}, 16'd0);
    next_cyc();

    // ALU 0x1234: low byte then high byte on consecutive cycles.
    bus.ALU_OUT_VALID = 1'b1; bus.ALU_OUT = 16'h1234;
    exp_q.push_back(8'h34); exp_q.push_back(8'h12);
    next_cyc(); clear_inputs();
    next_cyc(); at_neg();
    check("alu_b0_vld", {15'd0, bus.TX_D_VLD}, 16'd1);
    check("alu_b0_data", {8'd0, bus.TX_P_Data}, 16'h34);
    next_cyc(); at_neg();
    check("alu_b1_vld", {15'd0, bus.TX_D_VLD}, 16'd1);
    check("alu_b1_data", {8'd0, bus.TX_P_Data}, 16'h12);
    check("alu_b1_pend", {13'd0, pend}, 16'h1);
    next_cyc(); at_neg();
    check("alu_done_pend", {13'd0, pend}, 16'd0);
    check("alu_done_vld", {15'd0, bus.TX_D_VLD}, 16'd0);
    next_cyc();

    // RF pulse landing in its own completion cycle is accepted.
    bus.RdData_VALID = 1'b1; bus.RF_RdData = 8'h44; exp_q.push_back(8'h44);
    next_cyc(); clear_inputs();
    next_cyc();
    bus.RdData_VALID = 1'b1; bus.RF_RdData = 8'h55; exp_q.push_back(8'h55);
    next_cyc(); clear_inputs();
    at_neg();
    check("refill_pend", {13'd0, pend}, 16'h2);
    drain(20);
    check("refill_ovf", {13'd0, ovf}, 16'd0);

    // All three at once after reset: ALU first, never interleaved.
    do_reset();
    bus.ALU_OUT_VALID = 1'b1; bus.ALU_OUT  = 16'hBEEF;
    bus.RdData_VALID  = 1'b1; bus.RF_RdData = 8'h11;
    bus.ERR_VLD       = 1'b1; bus.ERR_CODE  = 8'hEE;
    exp_q.push_back(8'hEF); exp_q.push_back(8'hBE);
    exp_q.push_back(8'h11); exp_q.push_back(8'hEE);
    next_cyc(); clear_inputs();
    at_neg();
    check("all3_pend", {13'd0, pend}, 16'h7);
    drain(30);
    check("all3_pend_clr", {13'd0, pend}, 16'd0);

    // FIFO_FULL held for five cycles during SEND_B1.
    do_reset();
    bus.ALU_OUT_VALID = 1'b1; bus.ALU_OUT = 16'hBEEF;
    exp_q.push_back(8'hEF); exp_q.push_back(8'hBE);
    next_cyc(); clear_inputs();
    next_cyc();
    next_cyc();
    bus.FIFO_FULL = 1'b1;
    wr_mark = wr_cnt;
    for (int i = 0; i < 5; i++) begin
      at_neg();
      check("full_vld", {15'd0, bus.TX_D_VLD}, 16'd0);
      check("full_data", {8'd0, bus.TX_P_Data}, 16'hBE);
      check("full_state", {14'd0, state_dbg}, 16'd2);
      next_cyc();
    end
    bus.FIFO_FULL = 1'b0;
    drain(10);
    next_cyc();
    check("full_wr_once", 16'(wr_cnt - wr_mark), 16'd1);

    // Overflow: second RF pulse while the first is stuck behind a full FIFO.
    do_reset();
    bus.FIFO_FULL = 1'b1;
    bus.RdData_VALID = 1'b1; bus.RF_RdData = 8'h22; exp_q.push_back(8'h22);
    next_cyc(); clear_inputs();
    next_cyc();
    next_cyc();
    bus.RdData_VALID = 1'b1; bus.RF_RdData = 8'h33;
    next_cyc(); clear_inputs();
    at_neg();
    check("ovf_set", {13'd0, ovf}, 16'h2);
    check("ovf_pend", {13'd0, pend}, 16'h2);
    check("ovf_hold_data", {8'd0, bus.TX_P_Data}, 16'h22);
    next_cyc();
    bus.FIFO_FULL = 1'b0;
    wr_mark = wr_cnt;
    drain(10);
    repeat (4) next_cyc();
    check("ovf_one_wr", 16'(wr_cnt - wr_mark), 16'd1);
    check("ovf_sticky", {13'd0, ovf}, 16'h2);
    do_reset();
    check("ovf_cleared", {13'd0, ovf}, 16'd0);

    // Reset during SEND_B1 aborts the frame for good.
    bus.ALU_OUT_VALID = 1'b1; bus.ALU_OUT = 16'hCAFE;
    exp_q.push_back(8'hFE); exp_q.push_back(8'hCA);
    next_cyc(); clear_inputs();
    next_cyc();
    next_cyc();
    check("abort_pre_state", {14'd0, state_dbg}, 16'd2);
    rst_n = 1'b0;
    #1;
    check("abort_vld", {15'd0, bus.TX_D_VLD}, 16'd0);
    check("abort_pend", {13'd0, pend}, 16'd0);
    check("abort_busy", {15'd0, busy}, 16'd0);
    exp_q.delete();
    next_cyc();
    rst_n = 1'b1;
    wr_mark = wr_cnt;
    repeat (10) next_cyc();
    check("abort_no_wr", 16'(wr_cnt - wr_mark), 16'd0);
    check("abort_idle", {15'd0, busy}, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
